// File: rtl/efb_wb_arbiter_if.sv
// efb_wb_arbiter_if
//   Wishbone bus between the arbiter (master) and the EFB register file
//   (slave). A single-beat classic cycle: cyc and stb rise together, and
//   the slave answers with ack, plus dat_r for reads.
//
//   cyc    master->slave  bus cycle in progress
//   stb    master->slave  strobe, always equal to cyc here
//   we     master->slave  1 = write, 0 = read
//   adr    master->slave  register address   [ADDR_W]
//   dat_w  master->slave  write data          [DATA_W]
//   dat_r  slave->master  read data           [DATA_W]
//   ack    slave->master  access acknowledge
interface efb_wb_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cyc;
  logic              stb;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [DATA_W-1:0] dat_w;
  logic [DATA_W-1:0] dat_r;
  logic              ack;

  modport master (output cyc, stb, we, adr, dat_w, input dat_r, ack);
  modport slave  (input cyc, stb, we, adr, dat_w, output dat_r, ack);
endinterface

// File: rtl/efb_wb_arbiter.sv
// efb_wb_arbiter
//   Shares the EFB Wishbone slave between two requesters with round-robin
//   priority. Each requester holds req (and its fields) until it sees a
//   one-cycle done; err marks an access the watchdog had to terminate.
//   Every output is a register: the next-state logic computes the next
//   value of each output and a single clocked process stores it.
//
//   Clock, Reset            clock; asynchronous active-high reset
//   m0_* / m1_*             requester ports: req, we, addr, wdata in;
//                           rdata, done, err out
//   wb                      Wishbone master side of efb_wb_arbiter_if
//   busy                    high whenever the arbiter is not IDLE
//   grant                   port currently or most recently granted
//
//   Parameter TIMEOUT (>= 2): cycles a granted access may wait for ack.
module efb_wb_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  output logic              m1_err,
  efb_wb_arbiter_if.master  wb,
  output logic              busy,
  output logic              grant
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

  state_t            state, state_nx;
  logic [WD_W-1:0]   wdog, wdog_nx;
  logic              last_grant, last_grant_nx;
  logic              grant_nx, busy_nx;
  logic              cyc_q, cyc_nx;
  logic              we_q, we_nx;
  logic [ADDR_W-1:0] adr_q, adr_nx;
  logic [DATA_W-1:0] dat_q, dat_nx;
  logic [DATA_W-1:0] m0_rdata_nx, m1_rdata_nx;
  logic              m0_done_nx, m1_done_nx, m0_err_nx, m1_err_nx;
  logic              pick;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  assign wb.cyc   = cyc_q;
  assign wb.stb   = cyc_q;
  assign wb.we    = we_q;
  assign wb.adr   = adr_q;
  assign wb.dat_w = dat_q;

  // On a tie the port that did not win last time goes first.
  assign pick = (m0_req && m1_req) ? ~last_grant : m1_req;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; without this the tool would infer latches.
    state_nx      = state;
    wdog_nx       = wdog;
    last_grant_nx = last_grant;
    grant_nx      = grant;
    cyc_nx        = cyc_q;
    we_nx         = we_q;
    adr_nx        = adr_q;
    dat_nx        = dat_q;
    m0_rdata_nx   = m0_rdata;
    m1_rdata_nx   = m1_rdata;
    m0_done_nx    = 1'b0;
    m1_done_nx    = 1'b0;
    m0_err_nx     = 1'b0;
    m1_err_nx     = 1'b0;
    resp_data     = '0;
    resp_err      = 1'b0;

    unique case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nx      = ACCESS;
          wdog_nx       = '0;
          last_grant_nx = pick;
          grant_nx      = pick;
          cyc_nx        = 1'b1;
          we_nx         = pick ? m1_we : m0_we;
          adr_nx        = pick ? m1_addr : m0_addr;
          // Write data is only presented on writes; reads drive zero.
          if (pick) dat_nx = m1_we ? m1_wdata : '0;
          else      dat_nx = m0_we ? m0_wdata : '0;
        end
      end
      ACCESS: begin
        // Ack is checked first so an ack on the final watchdog cycle wins.
        if (wb.ack || wdog == WD_W'(TIMEOUT - 1)) begin
          resp_data = (wb.ack && !we_q) ? wb.dat_r : '0;
          resp_err  = !wb.ack;
          state_nx  = RECOVER;
          cyc_nx    = 1'b0;
          we_nx     = 1'b0;
          if (grant) begin
            m1_rdata_nx = resp_data;
            m1_done_nx  = 1'b1;
            m1_err_nx   = resp_err;
          end else begin
            m0_rdata_nx = resp_data;
            m0_done_nx  = 1'b1;
            m0_err_nx   = resp_err;
          end
        end else begin
          wdog_nx = wdog + WD_W'(1);
        end
      end
      RECOVER: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    busy_nx = (state_nx != IDLE);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      wdog       <= '0;
      last_grant <= 1'b1;  // makes port 0 win the first tie
      grant      <= 1'b0;
      busy       <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      m0_done    <= 1'b0;
      m1_done    <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values computed above, independent of statement order.
      state      <= state_nx;
      wdog       <= wdog_nx;
      last_grant <= last_grant_nx;
      grant      <= grant_nx;
      busy       <= busy_nx;
      cyc_q      <= cyc_nx;
      we_q       <= we_nx;
      adr_q      <= adr_nx;
      dat_q      <= dat_nx;
      m0_rdata   <= m0_rdata_nx;
      m1_rdata   <= m1_rdata_nx;
      m0_done    <= m0_done_nx;
      m1_done    <= m1_done_nx;
      m0_err     <= m0_err_nx;
      m1_err     <= m1_err_nx;
    end
  end

endmodule
